pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_renderer_if.sv | 29 ++
 rtl/pong_renderer.sv | 239 +++++++++++++++++++++++
 tb/tb_pong_renderer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_renderer_if.sv
// Video timing / pixel bus between a timing generator and the Pong renderer.
//   char_count, line_count_out : raster position from the timing generator
//   visible                    : high inside the active area
//   hsync, vsync               : sync pulses, active high
//   red, green, blue           : registered 4-bit colour channels
//   hsync_o, vsync_o           : syncs delayed to line up with the colour
// master = timing generator / sink side, slave = renderer.
interface pong_renderer_if;
    logic [11:0] char_count;
    logic [11:0] line_count_out;
    logic        visible;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync_o;
    logic        vsync_o;

    modport master (
        output char_count, line_count_out, visible, hsync, vsync,
        input  red, green, blue, hsync_o, vsync_o
    );

    modport slave (
        input  char_count, line_count_out, visible, hsync, vsync,
        output red, green, blue, hsync_o, vsync_o
    );
endinterface

// File: rtl/pong_renderer.sv
// Two-player Pong: game state machine plus a one-cycle pixel renderer.
//   pixel_clock    : sole clock
//   rst_n          : asynchronous active-low reset
//   video          : timing inputs in, registered colour and delayed syncs out
//   btn_*_up/dn    : asynchronous paddle buttons, active high
//   score_l/r      : BCD scores of the left/right player
// Game state advances once per frame, on the rising edge of the registered vsync.
module pong_renderer #(
    parameter int unsigned H_OFFSET     = 384,
    parameter int unsigned V_OFFSET     = 31,
    parameter int unsigned H_ACTIVE     = 1440,
    parameter int unsigned V_ACTIVE     = 900,
    parameter int unsigned BALL         = 16,
    parameter int unsigned PAD_W        = 16,
    parameter int unsigned PAD_H        = 128,
    parameter int unsigned PAD_LX       = 32,
    parameter int unsigned PAD_RX       = 1392,
    parameter int unsigned BALL_SPD     = 4,
    parameter int unsigned PAD_SPD      = 8,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic            pixel_clock,
    input  logic            rst_n,
    pong_renderer_if.slave  video,
    input  logic            btn_l_up,
    input  logic            btn_l_dn,
    input  logic            btn_r_up,
    input  logic            btn_r_dn,
    output logic [3:0]      score_l,
    output logic [3:0]      score_r
);

    localparam logic [11:0] HOff      = 12'(H_OFFSET);
    localparam logic [11:0] VOff      = 12'(V_OFFSET);
    localparam logic [11:0] BallSz    = 12'(BALL);
    localparam logic [11:0] PadW      = 12'(PAD_W);
    localparam logic [11:0] PadH      = 12'(PAD_H);
    localparam logic [11:0] PadLx     = 12'(PAD_LX);
    localparam logic [11:0] PadRx     = 12'(PAD_RX);
    localparam logic [11:0] BallSpd   = 12'(BALL_SPD);
    localparam logic [11:0] PadSpd    = 12'(PAD_SPD);
    localparam logic [11:0] LeftFace  = 12'(PAD_LX + PAD_W);
    localparam logic [11:0] RightFace = 12'(PAD_RX - BALL);
    localparam logic [11:0] XMax      = 12'(H_ACTIVE - BALL);
    localparam logic [11:0] YMax      = 12'(V_ACTIVE - BALL);
    localparam logic [11:0] PadMax    = 12'(V_ACTIVE - PAD_H);
    localparam logic [11:0] ServeX    = 12'(H_ACTIVE / 2 - BALL / 2);
    localparam logic [11:0] ServeY    = 12'(V_ACTIVE / 2 - BALL / 2);
    localparam logic [11:0] PadInit   = 12'(V_ACTIVE / 2 - PAD_H / 2);
    localparam logic [11:0] NetX0     = 12'(H_ACTIVE / 2 - 2);
    localparam logic [11:0] NetX1     = 12'(H_ACTIVE / 2 + 1);
    localparam logic [7:0]  PauseLast = 8'(PAUSE_FRAMES - 1);

    typedef enum logic [1:0] {StServe, StPlay, StPause} state_e;

    function automatic logic in_box(logic [11:0] px, logic [11:0] py, logic [11:0] bx,
                                    logic [11:0] by, logic [11:0] w, logic [11:0] h);
        return (px >= bx) && (px < bx + w) && (py >= by) && (py < by + h);
    endfunction

    // Clamped paddle move; opposing buttons cancel.
    function automatic logic [11:0] pad_step(logic [11:0] p, logic up, logic dn);
        logic [11:0] r;
        r = p;
        if (up && !dn) begin
            r = (p < PadSpd) ? 12'd0 : p - PadSpd;
        end else if (dn && !up) begin
            r = (p + PadSpd > PadMax) ? PadMax : p + PadSpd;
        end
        return r;
    endfunction

    function automatic logic [3:0] bcd_inc(logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // {l_up, l_dn, r_up, r_dn}
    logic [3:0]  btn_meta_q, btn_sync_q;
    logic        hsync_q, vsync_q, vsync_prev_q;
    logic [11:0] colour_q, colour_d;
    state_e      state_q, state_d;
    logic [11:0] bx_q, bx_d, by_q, by_d, ly_q, ly_d, ry_q, ry_d;
    logic        dx_q, dx_d, dy_q, dy_d;  // dx 1 = right, dy 1 = down
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sl_q, sl_d, sr_q, sr_d;
    logic [11:0] x, y;
    logic        frame_tick, ovl_l, ovl_r;

    assign x          = video.char_count - HOff;
    assign y          = video.line_count_out - VOff;
    assign frame_tick = vsync_q & ~vsync_prev_q;

    // Vertical overlap of the ball with each paddle, using pre-tick positions.
    assign ovl_l = (by_q < ly_q + PadH) && (ly_q < by_q + BallSz);
    assign ovl_r = (by_q < ry_q + PadH) && (ry_q < by_q + BallSz);

    always_comb begin
        colour_d = 12'h000;
        if (video.visible) begin
            if (state_q != StPause && in_box(x, y, bx_q, by_q, BallSz, BallSz)) begin
                colour_d = 12'hFFF;
            end else if (in_box(x, y, PadLx, ly_q, PadW, PadH) ||
                         in_box(x, y, PadRx, ry_q, PadW, PadH)) begin
                colour_d = 12'h0F0;
            end else if (x >= NetX0 && x <= NetX1 && !y[4]) begin
                colour_d = 12'h888;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        ly_d    = ly_q;
        ry_d    = ry_q;
        if (frame_tick) begin
            ly_d = pad_step(ly_q, btn_sync_q[3], btn_sync_q[2]);
            ry_d = pad_step(ry_q, btn_sync_q[1], btn_sync_q[0]);
            unique case (state_q)
                StServe: begin
                    bx_d    = ServeX;
                    by_d    = ServeY;
                    dy_d    = 1'b1;
                    state_d = StPlay;
                end
                StPlay: begin
                    // A miss wins over any paddle check; dx is left pointing at the
                    // player who conceded so the next serve goes their way.
                    if (!dx_q && bx_q < BallSpd) begin
                        sr_d    = bcd_inc(sr_q);
                        dx_d    = 1'b0;
                        cnt_d   = 8'd0;
                        state_d = StPause;
                    end else if (dx_q && bx_q + BallSpd > XMax) begin
                        sl_d    = bcd_inc(sl_q);
                        dx_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StPause;
                    end else begin
                        if (dx_q) begin
                            if (bx_q + BallSpd > RightFace && bx_q <= RightFace && ovl_r) begin
                                bx_d = RightFace;
                                dx_d = 1'b0;
                            end else begin
                                bx_d = bx_q + BallSpd;
                            end
                        end else begin
                            if (bx_q - BallSpd < LeftFace && bx_q >= LeftFace && ovl_l) begin
                                bx_d = LeftFace;
                                dx_d = 1'b1;
                            end else begin
                                bx_d = bx_q - BallSpd;
                            end
                        end
                        if (dy_q) begin
                            if (by_q + BallSpd > YMax) begin
                                by_d = YMax;
                                dy_d = 1'b0;
                            end else begin
                                by_d = by_q + BallSpd;
                            end
                        end else begin
                            if (by_q < BallSpd) begin
                                by_d = 12'd0;
                                dy_d = 1'b1;
                            end else begin
                                by_d = by_q - BallSpd;
                            end
                        end
                    end
                end
                StPause: begin
                    if (cnt_q == PauseLast) begin
                        cnt_d   = 8'd0;
                        bx_d    = ServeX;
                        by_d    = ServeY;
                        state_d = StServe;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = StServe;
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q   <= 4'd0;
            btn_sync_q   <= 4'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            colour_q     <= 12'h000;
            state_q      <= StServe;
            bx_q         <= ServeX;
            by_q         <= ServeY;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            cnt_q        <= 8'd0;
            sl_q         <= 4'd0;
            sr_q         <= 4'd0;
            ly_q         <= PadInit;
            ry_q         <= PadInit;
        end else begin
            btn_meta_q   <= {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn};
            btn_sync_q   <= btn_meta_q;
            hsync_q      <= video.hsync;
            vsync_q      <= video.vsync;
            vsync_prev_q <= vsync_q;
            colour_q     <= colour_d;
            state_q      <= state_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            cnt_q        <= cnt_d;
            sl_q         <= sl_d;
            sr_q         <= sr_d;
            ly_q         <= ly_d;
            ry_q         <= ry_d;
        end
    end

    assign video.red     = colour_q[11:8];
    assign video.green   = colour_q[7:4];
    assign video.blue    = colour_q[3:0];
    assign video.hsync_o = hsync_q;
    assign video.vsync_o = vsync_q;
    assign score_l       = sl_q;
    assign score_r       = sr_q;

endmodule

// File: tb/tb_pong_renderer.sv
module tb_pong_renderer;
    localparam int HO = 384;
    localparam int VO = 31;
    localparam int SERVE = 0;
    localparam int PLAY = 1;
    localparam int PAUSE = 2;

    logic       pixel_clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [3:0] score_l, score_r;
    int         n_pass = 0;
    int         n_total = 0;

    pong_renderer_if vid ();

    pong_renderer dut (
        .pixel_clock(pixel_clock),
        .rst_n      (rst_n),
        .video      (vid),
        .btn_l_up   (btn_l_up),
        .btn_l_dn   (btn_l_dn),
        .btn_r_up   (btn_r_up),
        .btn_r_dn   (btn_r_dn),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Reference game: positions as plain integers, directions as +1/-1.
    int m_state, m_bx, m_by, m_dx, m_dy, m_ly, m_ry, m_sl, m_sr, m_cnt;

    task automatic m_reset();
        m_state = SERVE; m_bx = 712; m_by = 442; m_dx = 1; m_dy = 1;
        m_ly = 386; m_ry = 386; m_sl = 0; m_sr = 0; m_cnt = 0;
    endtask

    function automatic int pad_move(int p, bit up, bit dn);
        int n;
        n = p;
        if (up != dn) n = p + (dn ? 8 : -8);
        if (n < 0) n = 0;
        if (n > 900 - 128) n = 900 - 128;
        return n;
    endfunction

    task automatic m_tick();
        int nx, ny, oly, ory;
        bit ovl_l, ovl_r;
        oly = m_ly; ory = m_ry;
        m_ly = pad_move(m_ly, btn_l_up, btn_l_dn);
        m_ry = pad_move(m_ry, btn_r_up, btn_r_dn);
        if (m_state == SERVE) begin
            m_bx = 712; m_by = 442; m_dy = 1; m_state = PLAY;
        end else if (m_state == PLAY) begin
            nx = m_bx + 4 * m_dx;
            if (nx < 0) begin
                m_sr = (m_sr + 1) % 10; m_dx = -1; m_state = PAUSE; m_cnt = 0;
            end else if (nx > 1440 - 16) begin
                m_sl = (m_sl + 1) % 10; m_dx = 1; m_state = PAUSE; m_cnt = 0;
            end else begin
                ovl_l = (m_by < oly + 128) && (oly < m_by + 16);
                ovl_r = (m_by < ory + 128) && (ory < m_by + 16);
                // Ball face crossing a paddle face this frame snaps to the face.
                if (m_dx < 0 && m_bx >= 48 && nx < 48 && ovl_l) begin
                    nx = 48; m_dx = 1;
                end else if (m_dx > 0 && m_bx <= 1376 && nx > 1376 && ovl_r) begin
                    nx = 1376; m_dx = -1;
                end
                ny = m_by + 4 * m_dy;
                if (ny < 0) begin
                    ny = 0; m_dy = 1;
                end else if (ny > 900 - 16) begin
                    ny = 900 - 16; m_dy = -1;
                end
                m_bx = nx; m_by = ny;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_state = SERVE; m_cnt = 0; m_bx = 712; m_by = 442;
            end
        end
    endtask

    function automatic logic [11:0] m_pixel(int x, int y, bit vis);
        if (!vis) return 12'h000;
        if (m_state != PAUSE && x >= m_bx && x < m_bx + 16 && y >= m_by && y < m_by + 16)
            return 12'hFFF;
        if (x >= 32 && x < 48 && y >= m_ly && y < m_ly + 128) return 12'h0F0;
        if (x >= 1392 && x < 1408 && y >= m_ry && y < m_ry + 128) return 12'h0F0;
        if (x >= 718 && x <= 721 && y >= 0 && ((y / 16) % 2) == 0) return 12'h888;
        return 12'h000;
    endfunction

    // Drive one pixel position and return the colour registered from it.
    task automatic sample_pixel(input int x, input int y, input bit vis, output logic [11:0] c);
        vid.char_count     = 12'(x + HO);
        vid.line_count_out = 12'(y + VO);
        vid.visible        = vis;
        @(posedge pixel_clock); #1;
        c = {vid.red, vid.green, vid.blue};
    endtask

    task automatic do_tick();
        vid.visible = 1'b0;
        vid.vsync   = 1'b1;
        @(posedge pixel_clock); #1;
        vid.vsync = 1'b0;
        repeat (2) begin @(posedge pixel_clock); #1; end
        m_tick();
    endtask

    task automatic set_buttons(input bit lu, input bit ld, input bit ru, input bit rd);
        if ({btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} != {lu, ld, ru, rd}) begin
            btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
            repeat (3) begin @(posedge pixel_clock); #1; end
        end
    endtask

    task automatic test_reset();
        logic [11:0] c, e;
        int px[6] = '{712, 727, 728, 32, 32, 720};
        int py[6] = '{442, 457, 442, 386, 385, 0};
        vid.char_count = 12'(HO + 712); vid.line_count_out = 12'(VO + 442);
        vid.visible = 1'b1; vid.hsync = 1'b1; vid.vsync = 1'b0;
        repeat (3) begin @(posedge pixel_clock); #1; end
        n_total++;
        if ({vid.red, vid.green, vid.blue, vid.hsync_o, vid.vsync_o, score_l, score_r} !== 22'd0)
            $display("FAIL reset_hold: got colour=%h hs=%b vs=%b sl=%0d sr=%0d, want all 0",
                     {vid.red, vid.green, vid.blue}, vid.hsync_o, vid.vsync_o, score_l, score_r);
        else n_pass++;
        rst_n = 1'b1;
        m_reset();
        sample_pixel(712, 442, 1'b1, c);
        n_total++;
        if (c !== 12'hFFF) $display("FAIL serve_ball: got %h want FFF", c);
        else n_pass++;
        do_tick();
        for (int i = 0; i < 6; i++) begin
            sample_pixel(px[i], py[i], 1'b1, c);
            e = m_pixel(px[i], py[i], 1'b1);
            n_total++;
            if (c !== e) $display("FAIL first_tick_px(%0d,%0d): got %h want %h", px[i], py[i], c, e);
            else n_pass++;
        end
        sample_pixel(720, 16, 1'b1, c);
        n_total++;
        if (c !== 12'h000) $display("FAIL net_gap: got %h want 000", c);
        else n_pass++;
    endtask

    task automatic test_sync();
        bit h, v, ph, pv;
        ph = vid.hsync; pv = 1'b0;
        for (int i = 0; i < 48; i++) begin
            h = 1'($urandom); v = 1'($urandom);
            vid.hsync = h; vid.vsync = v; vid.visible = 1'b0;
            vid.char_count = 12'($urandom); vid.line_count_out = 12'($urandom);
            #1;
            n_total++;
            if ({vid.hsync_o, vid.vsync_o} !== {ph, pv})
                $display("FAIL sync_hold[%0d]: got %b%b want %b%b", i, vid.hsync_o, vid.vsync_o, ph, pv);
            else n_pass++;
            @(posedge pixel_clock); #1;
            n_total++;
            if ({vid.hsync_o, vid.vsync_o, vid.red, vid.green, vid.blue} !== {h, v, 12'h000})
                $display("FAIL sync_delay[%0d]: got hs=%b vs=%b colour=%h want hs=%b vs=%b 000", i,
                         vid.hsync_o, vid.vsync_o, {vid.red, vid.green, vid.blue}, h, v);
            else n_pass++;
            if (v && !pv) m_tick();
            ph = h; pv = v;
        end
        vid.vsync = 1'b0;
        repeat (3) begin @(posedge pixel_clock); #1; end
    endtask

    task automatic test_paddle();
        logic [11:0] c, e;
        set_buttons(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) begin
            do_tick();
            n_total++;
            if ({score_l, score_r} !== 8'(m_sl * 16 + m_sr))
                $display("FAIL paddle_score[%0d]: got %0d/%0d want %0d/%0d", i, score_l, score_r, m_sl, m_sr);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            sample_pixel(32, i * 64, 1'b1, c);
            e = m_pixel(32, i * 64, 1'b1);
            n_total++;
            if (c !== e || e !== (i < 2 ? 12'h0F0 : 12'h000))
                $display("FAIL paddle_top(y=%0d): got %h want %h", i * 64, c, (i < 2) ? 12'h0F0 : 12'h000);
            else n_pass++;
        end
        set_buttons(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) do_tick();
        sample_pixel(32, m_ly + 127, 1'b1, c);
        n_total++;
        if (c !== m_pixel(32, m_ly + 127, 1'b1)) $display("FAIL paddle_both: got %h", c);
        else n_pass++;
        sample_pixel(1392, m_ry - 1, 1'b1, c);
        e = m_pixel(1392, m_ry - 1, 1'b1);
        n_total++;
        if (c !== e) $display("FAIL paddle_dn_edge: got %h want %h", c, e);
        else n_pass++;
        sample_pixel(1407, m_ry, 1'b1, c);
        e = m_pixel(1407, m_ry, 1'b1);
        n_total++;
        if (c !== e) $display("FAIL paddle_dn: got %h want %h", c, e);
        else n_pass++;
    endtask

    // Paddle steering: 'track' follows the ball, otherwise it runs away from it.
    task automatic steer(input int p, input bit track, output bit up, output bit dn);
        int pc, bc;
        pc = p + 64; bc = m_by + 8;
        if (track) begin
            up = pc > bc + 4; dn = pc < bc - 4;
        end else begin
            up = bc >= pc; dn = !up;
        end
    endtask

    task automatic test_rally();
        logic [11:0] c, e;
        bit lu, ld, ru, rd, wrap_l, done;
        int prev_sl;
        wrap_l = 1'b0; done = 1'b0;
        for (int t = 0; t < 7000 && !done; t++) begin
            // First let the left player concede twice, then let the right concede.
            steer(m_ly, m_sr >= 2, lu, ld);
            steer(m_ry, m_sr < 2, ru, rd);
            set_buttons(lu, ld, ru, rd);
            prev_sl = m_sl;
            do_tick();
            if (prev_sl == 9 && m_sl == 0) wrap_l = 1'b1;
            n_total++;
            if ({score_l, score_r} !== 8'(m_sl * 16 + m_sr))
                $display("FAIL rally_score[%0d]: got %0d/%0d want %0d/%0d", t, score_l, score_r, m_sl, m_sr);
            else n_pass++;
            sample_pixel(m_bx, m_by, 1'b1, c);
            e = m_pixel(m_bx, m_by, 1'b1);
            n_total++;
            if (c !== e) $display("FAIL rally_ball[%0d] (%0d,%0d): got %h want %h", t, m_bx, m_by, c, e);
            else n_pass++;
            sample_pixel(m_bx + 16, m_by + 15, (t % 7) != 0, c);
            e = m_pixel(m_bx + 16, m_by + 15, (t % 7) != 0);
            n_total++;
            if (c !== e) $display("FAIL rally_edge[%0d]: got %h want %h", t, c, e);
            else n_pass++;
            done = wrap_l && m_sr >= 2;
        end
        n_total++;
        if (!done) $display("FAIL rally_budget: got sl=%0d sr=%0d wrap=%b, want wrap and sr>=2", m_sl, m_sr, wrap_l);
        else n_pass++;
    endtask

    task automatic test_reset_pause();
        logic [11:0] c, e;
        set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 1000 && m_state != PAUSE; t++) do_tick();
        repeat (5) do_tick();
        vid.hsync = 1'b1;
        sample_pixel(32, m_ly, 1'b1, c);
        n_total++;
        if (c !== 12'h0F0) $display("FAIL pause_paddle: got %h want 0F0", c);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({vid.red, vid.green, vid.blue, vid.hsync_o, score_l, score_r} !== 21'd0)
            $display("FAIL async_reset: got colour=%h hs=%b sl=%0d sr=%0d want 0",
                     {vid.red, vid.green, vid.blue}, vid.hsync_o, score_l, score_r);
        else n_pass++;
        @(posedge pixel_clock); #1;
        rst_n = 1'b1;
        m_reset();
        sample_pixel(712, 442, 1'b1, c);
        n_total++;
        if (c !== 12'hFFF) $display("FAIL reset_serve: got %h want FFF", c);
        else n_pass++;
        repeat (4) do_tick();
        sample_pixel(m_bx + 15, m_by, 1'b1, c);
        n_total++;
        if (c !== 12'hFFF || m_bx != 724) $display("FAIL resume_ball: got %h want FFF", c);
        else n_pass++;
        sample_pixel(32, 385, 1'b1, c);
        e = m_pixel(32, 385, 1'b1);
        n_total++;
        if (c !== e) $display("FAIL reset_paddle: got %h want %h", c, e);
        else n_pass++;
    endtask

    initial begin
        vid.char_count = '0; vid.line_count_out = '0; vid.visible = 1'b0;
        vid.hsync = 1'b0; vid.vsync = 1'b0;
        m_reset();
        test_reset();
        test_sync();
        test_paddle();
        test_rally();
        test_reset_pause();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
